// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer: load-use / branch hazard control, multi-cycle MUL/DIV
// sequencing in EX, and a saturating stall-cycle performance counter.
module hazard_stall_ctrl #(
   parameter int unsigned MDU_LAT = 8,
   parameter int unsigned CNT_W   = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [4:0]       ID_rs,
   input  logic [4:0]       ID_rt,
   input  logic             ID_UsesRt,
   input  logic             EX_MemToReg,
   input  logic             EX_RegWrite,
   input  logic [4:0]       EX_WriteReg,
   input  logic             EX_BrTaken,
   input  logic             EX_Jump,
   input  logic             EX_MduStart,
   output logic             pc_stall,
   output logic             if_id_stall,
   output logic             id_ex_stall,
   output logic             id_ex_hold,
   output logic             ex_mem_bubble,
   output logic             flush,
   output logic             mdu_busy,
   output logic             mdu_done,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [7:0]       CNT_LOAD = 8'(MDU_LAT - 2);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t     state, state_nxt;
   logic [7:0] cnt, cnt_nxt;
   logic       lu, ctl, mdu_active;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // cnt holds the BUSY cycles still to run, counting the current one; leaving
   // BUSY as the decrement reaches zero keeps EX occupancy at exactly MDU_LAT.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (EX_MduStart) begin
               cnt_nxt   = CNT_LOAD;
               state_nxt = (CNT_LOAD == 8'd0) ? DONE : BUSY;
            end
         end
         BUSY: begin
            cnt_nxt = cnt - 8'd1;
            if (cnt <= 8'd1) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign lu = EX_MemToReg & EX_RegWrite & (EX_WriteReg != 5'd0) &
               ((EX_WriteReg == ID_rs) | (ID_UsesRt & (EX_WriteReg == ID_rt)));
   assign ctl = EX_BrTaken | EX_Jump;
   assign mdu_active = ((state == IDLE) & EX_MduStart) | (state == BUSY);

   always_comb begin
      pc_stall      = 1'b0;
      if_id_stall   = 1'b0;
      id_ex_stall   = 1'b0;
      id_ex_hold    = 1'b0;
      ex_mem_bubble = 1'b0;
      flush         = 1'b0;
      mdu_busy      = 1'b0;
      mdu_done      = 1'b0;
      if (reset_n) begin
         mdu_busy = (state == BUSY);
         if (mdu_active) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_hold    = 1'b1;
            ex_mem_bubble = 1'b1;
         end else begin
            mdu_done = (state == DONE);
            if (ctl) begin
               flush       = 1'b1;
               id_ex_stall = 1'b1;
            end else if (lu) begin
               pc_stall    = 1'b1;
               if_id_stall = 1'b1;
               id_ex_stall = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt <= '0;
      end else if (pc_stall && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: a 32-bit counter build and a 4-bit
// counter build share stimulus so saturation can be observed.
module tb_hazard_stall_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [4:0]  ID_rs, ID_rt, EX_WriteReg;
   logic        ID_UsesRt, EX_MemToReg, EX_RegWrite, EX_BrTaken, EX_Jump, EX_MduStart;
   logic        pc_stall, if_id_stall, id_ex_stall, id_ex_hold, ex_mem_bubble, flush, mdu_busy, mdu_done;
   logic [31:0] stall_cnt;
   logic        s_pc_stall, s_if_id_stall, s_id_ex_stall, s_id_ex_hold, s_ex_mem_bubble, s_flush, s_mdu_busy, s_mdu_done;
   logic [3:0]  s_stall_cnt;

   int checks   = 0;
   int failures = 0;
   int exp_cnt  = 0;
   logic [7:0] outs, exp_outs;
   logic [3:0] exp_small;

   // {pc_stall, if_id_stall, id_ex_stall, id_ex_hold, ex_mem_bubble, flush, mdu_busy, mdu_done}
   assign outs = {pc_stall, if_id_stall, id_ex_stall, id_ex_hold, ex_mem_bubble, flush, mdu_busy, mdu_done};

   localparam logic [7:0] O_NONE  = 8'b0000_0000;
   localparam logic [7:0] O_LU    = 8'b1110_0000;
   localparam logic [7:0] O_CTL   = 8'b0010_0100;
   localparam logic [7:0] O_MDU1  = 8'b1101_1000;
   localparam logic [7:0] O_MDUB  = 8'b1101_1010;
   localparam logic [7:0] O_DONE  = 8'b0000_0001;

   hazard_stall_ctrl #(.MDU_LAT(8), .CNT_W(32)) u_dut (
      .clk(clk), .reset_n(reset_n), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UsesRt(ID_UsesRt),
      .EX_MemToReg(EX_MemToReg), .EX_RegWrite(EX_RegWrite), .EX_WriteReg(EX_WriteReg),
      .EX_BrTaken(EX_BrTaken), .EX_Jump(EX_Jump), .EX_MduStart(EX_MduStart),
      .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
      .id_ex_hold(id_ex_hold), .ex_mem_bubble(ex_mem_bubble), .flush(flush),
      .mdu_busy(mdu_busy), .mdu_done(mdu_done), .stall_cnt(stall_cnt)
   );

   hazard_stall_ctrl #(.MDU_LAT(8), .CNT_W(4)) u_small (
      .clk(clk), .reset_n(reset_n), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UsesRt(ID_UsesRt),
      .EX_MemToReg(EX_MemToReg), .EX_RegWrite(EX_RegWrite), .EX_WriteReg(EX_WriteReg),
      .EX_BrTaken(EX_BrTaken), .EX_Jump(EX_Jump), .EX_MduStart(EX_MduStart),
      .pc_stall(s_pc_stall), .if_id_stall(s_if_id_stall), .id_ex_stall(s_id_ex_stall),
      .id_ex_hold(s_id_ex_hold), .ex_mem_bubble(s_ex_mem_bubble), .flush(s_flush),
      .mdu_busy(s_mdu_busy), .mdu_done(s_mdu_done), .stall_cnt(s_stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                         input logic mtr, input logic rw, input logic [4:0] wr,
                         input logic br, input logic jmp, input logic mdu);
      ID_rs = rs; ID_rt = rt; ID_UsesRt = uses;
      EX_MemToReg = mtr; EX_RegWrite = rw; EX_WriteReg = wr;
      EX_BrTaken = br; EX_Jump = jmp; EX_MduStart = mdu;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      set_in(5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1);
      #1;
      checks++;
      if (outs !== O_NONE) begin
         failures++;
         $display("FAIL reset_outputs: got %b expected %b", outs, O_NONE);
      end
      checks++;
      if (stall_cnt !== 32'd0 || s_stall_cnt !== 4'd0) begin
         failures++;
         $display("FAIL reset_stall_cnt: got %0d/%0d expected 0/0", stall_cnt, s_stall_cnt);
      end
      set_in('0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      #2 reset_n = 1'b1;
      tick();
      checks++;
      if (outs !== O_NONE || stall_cnt !== 32'd0) begin
         failures++;
         $display("FAIL post_reset_idle: got %b cnt %0d expected %b cnt 0", outs, stall_cnt, O_NONE);
      end
   endtask

   task automatic test_load_use();
      // lw $5 in EX, ID reads $5 through rs
      set_in(5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
      #1;
      checks++;
      if (outs !== O_LU) begin
         failures++;
         $display("FAIL lu_rs: got %b expected %b", outs, O_LU);
      end
      tick();
      exp_cnt++;
      set_in(5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      #1;
      checks++;
      if (outs !== O_NONE || stall_cnt !== 32'(exp_cnt)) begin
         failures++;
         $display("FAIL lu_one_bubble: got %b cnt %0d expected %b cnt %0d", outs, stall_cnt, O_NONE, exp_cnt);
      end
      // rt match with ID_UsesRt=1
      set_in(5'd1, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
      #1;
      checks++;
      if (outs !== O_LU) begin
         failures++;
         $display("FAIL lu_rt: got %b expected %b", outs, O_LU);
      end
      tick();
      exp_cnt++;
      set_in('0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      tick();
      checks++;
      if (stall_cnt !== 32'(exp_cnt)) begin
         failures++;
         $display("FAIL lu_count: got %0d expected %0d", stall_cnt, exp_cnt);
      end
   endtask

   task automatic test_no_hazard();
      logic [4:0] rs_v [4] = '{5'd0, 5'd3, 5'd5, 5'd5};
      logic [4:0] rt_v [4] = '{5'd0, 5'd5, 5'd0, 5'd0};
      logic [4:0] wr_v [4] = '{5'd0, 5'd5, 5'd5, 5'd5};
      logic       mtr_v [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
      logic       rw_v [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      for (int unsigned i = 0; i < 4; i++) begin
         set_in(rs_v[i], rt_v[i], 1'b0, mtr_v[i], rw_v[i], wr_v[i], 1'b0, 1'b0, 1'b0);
         #1;
         checks++;
         if (outs !== O_NONE) begin
            failures++;
            $display("FAIL no_hazard_%0d: got %b expected %b", i, outs, O_NONE);
         end
         tick();
      end
      checks++;
      if (stall_cnt !== 32'(exp_cnt)) begin
         failures++;
         $display("FAIL no_hazard_count: got %0d expected %0d", stall_cnt, exp_cnt);
      end
   endtask

   task automatic test_branch();
      set_in(5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
      #1;
      checks++;
      if (outs !== O_CTL) begin
         failures++;
         $display("FAIL branch_over_lu: got %b expected %b", outs, O_CTL);
      end
      tick();
      set_in('0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
      #1;
      checks++;
      if (outs !== O_CTL) begin
         failures++;
         $display("FAIL jump: got %b expected %b", outs, O_CTL);
      end
      tick();
      set_in('0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (stall_cnt !== 32'(exp_cnt)) begin
         failures++;
         $display("FAIL branch_count: got %0d expected %0d", stall_cnt, exp_cnt);
      end
   endtask

   // Two back-to-back ops with start held; the first carries lu+branch noise
   // which the MDU must override, and lu in its DONE cycle still stalls.
   task automatic test_back_to_back();
      for (int unsigned c = 1; c <= 16; c++) begin
         int unsigned k;
         k = (c - 1) % 8 + 1;
         if (c <= 8 && k <= 7)
            set_in(5'd9, 5'd0, 1'b0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1);
         else if (c == 8)
            set_in(5'd9, 5'd0, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1);
         else
            set_in('0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
         if (k == 1)      exp_outs = O_MDU1;
         else if (k <= 7) exp_outs = O_MDUB;
         else if (c == 8) exp_outs = O_LU | O_DONE;
         else             exp_outs = O_DONE;
         #1;
         checks++;
         if (outs !== exp_outs) begin
            failures++;
            $display("FAIL mdu_cycle_%0d: got %b expected %b", c, outs, exp_outs);
         end
         tick();
         if (exp_outs[7]) exp_cnt++;
      end
      set_in('0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      #1;
      checks++;
      if (outs !== O_NONE || stall_cnt !== 32'(exp_cnt)) begin
         failures++;
         $display("FAIL mdu_end: got %b cnt %0d expected %b cnt %0d", outs, stall_cnt, O_NONE, exp_cnt);
      end
      tick();
   endtask

   task automatic test_reset_mid_busy();
      set_in('0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
      tick();
      tick();
      #1;
      checks++;
      if (outs !== O_MDUB) begin
         failures++;
         $display("FAIL busy_cycle3: got %b expected %b", outs, O_MDUB);
      end
      #2 reset_n = 1'b0;
      #1;
      exp_cnt = 0;
      checks++;
      if (outs !== O_NONE || stall_cnt !== 32'd0) begin
         failures++;
         $display("FAIL async_abort: got %b cnt %0d expected %b cnt 0", outs, stall_cnt, O_NONE);
      end
      EX_MduStart = 1'b0;
      #2 reset_n = 1'b1;
      for (int unsigned c = 0; c < 10; c++) begin
         tick();
         checks++;
         if (outs !== O_NONE || stall_cnt !== 32'd0) begin
            failures++;
            $display("FAIL after_abort_%0d: got %b cnt %0d expected %b cnt 0", c, outs, stall_cnt, O_NONE);
         end
      end
   endtask

   task automatic test_saturation();
      set_in(5'd3, 5'd0, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
      for (int unsigned c = 0; c < 20; c++) begin
         tick();
         exp_cnt++;
         exp_small = (exp_cnt > 15) ? 4'hF : 4'(exp_cnt);
         checks++;
         if (stall_cnt !== 32'(exp_cnt) || s_stall_cnt !== exp_small) begin
            failures++;
            $display("FAIL sat_step_%0d: got %0d/%h expected %0d/%h", c, stall_cnt, s_stall_cnt, exp_cnt, exp_small);
         end
      end
      set_in('0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      tick();
      checks++;
      if (s_stall_cnt !== 4'hF) begin
         failures++;
         $display("FAIL sat_hold: got %h expected f", s_stall_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_no_hazard();
      test_branch();
      test_back_to_back();
      test_reset_mid_busy();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
